// File: rtl/vga_write_arbiter_pkg.sv
// Shared widths, screen geometry and arbiter state encoding for the vga_write_arbiter slice.
package vga_write_arbiter_pkg;

   localparam int unsigned X_W      = 8;
   localparam int unsigned Y_W      = 7;
   localparam int unsigned COLOUR_W = 15;
   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned IDX_W    = 2;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   // Increment a requester index, wrapping at n.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                 input int unsigned n);
      if (32'(idx) + 1 >= n) return '0;
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder; first set req bit scanning from ptr upward.
import vga_write_arbiter_pkg::*;

module rr_pick #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   logic [3:0] req4;
   assign req4 = 4'(req);

   always_comb begin
      int unsigned cand;
      cand  = 0;
      found = 1'b0;
      index = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!found && req4[IDX_W'(cand)]) begin
            found = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin pixel-write arbiter with burst lock and idle timeout feeding vga_adapter.
// Optional out-of-range beat dropping is enabled by defining VGA_ARB_CLIP_EN.
import vga_write_arbiter_pkg::*;

module vga_write_arbiter #(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned XMAX         = 159,
   parameter int unsigned YMAX         = 119,
   parameter int unsigned LOCK_TIMEOUT = 64
) (
   input  logic                         CLOCK,
   input  logic                         resetn,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [X_W*NUM_REQ-1:0]       req_x,
   input  logic [Y_W*NUM_REQ-1:0]       req_y,
   input  logic [COLOUR_W*NUM_REQ-1:0]  req_colour,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [X_W-1:0]               x,
   output logic [Y_W-1:0]               y,
   output logic [COLOUR_W-1:0]          colour,
   output logic                         writeEn,
   output logic [1:0]                   owner,
   output logic                         locked,
   output logic [7:0]                   clip_cnt
);

   localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   arb_state_t           state;
   logic [IDX_W-1:0]     rr_ptr;
   logic [CNT_W-1:0]     idle_cnt;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     grant_idx;
   logic                 accept;
   logic                 beat_last;
   logic                 clip;
   logic [3:0]           valid4;
   logic [3:0]           last4;
   logic [X_W-1:0]       sel_x;
   logic [Y_W-1:0]       sel_y;
   logic [COLOUR_W-1:0]  sel_colour;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .index (pick_idx)
   );

   assign valid4    = 4'(req_valid);
   assign last4     = 4'(req_last);
   assign grant_idx = (state == ARB_LOCK) ? owner : pick_idx;
   assign accept    = (state == ARB_LOCK) ? valid4[owner] : pick_found;
   assign beat_last = last4[grant_idx];
   assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
   assign locked    = (state == ARB_LOCK);

   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == grant_idx) begin
            sel_x      = req_x[i*X_W +: X_W];
            sel_y      = req_y[i*Y_W +: Y_W];
            sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
         end
      end
   end

`ifdef VGA_ARB_CLIP_EN
   assign clip = (32'(sel_x) > XMAX) || (32'(sel_y) > YMAX);

   always_ff @(posedge CLOCK or negedge resetn) begin
      if (!resetn)
         clip_cnt <= '0;
      else if (accept && clip && clip_cnt != 8'hFF)
         clip_cnt <= clip_cnt + 8'd1;
   end
`else
   assign clip     = 1'b0;
   assign clip_cnt = '0;
`endif

   always_ff @(posedge CLOCK or negedge resetn) begin
      if (!resetn) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         idle_cnt <= '0;
         owner    <= '0;
         writeEn  <= 1'b0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
      end else begin
         writeEn <= accept & ~clip;
         if (accept && !clip) begin
            x      <= sel_x;
            y      <= sel_y;
            colour <= sel_colour;
         end
         case (state)
            ARB_IDLE: begin
               idle_cnt <= '0;
               if (accept) begin
                  owner <= grant_idx;
                  if (beat_last) rr_ptr <= wrap_inc(grant_idx, NUM_REQ);
                  else           state  <= ARB_LOCK;
               end
            end
            ARB_LOCK: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (beat_last) begin
                     state  <= ARB_IDLE;
                     rr_ptr <= wrap_inc(owner, NUM_REQ);
                  end
               end else if (LOCK_TIMEOUT != 0 && 32'(idle_cnt) == LOCK_TIMEOUT - 1) begin
                  // The stalled owner has been idle LOCK_TIMEOUT cycles including this one.
                  state    <= ARB_IDLE;
                  idle_cnt <= '0;
                  rr_ptr   <= wrap_inc(owner, NUM_REQ);
               end else begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench for vga_write_arbiter: stimulus pushes expected pixels, a negedge monitor pops them.
module tb_vga_write_arbiter;

   typedef struct packed {
      logic [7:0]  px;
      logic [6:0]  py;
      logic [14:0] pc;
   } pix_t;

   logic        CLOCK;
   logic        resetn;
   logic [2:0]  req_valid;
   logic [2:0]  req_last;
   logic [23:0] req_x;
   logic [20:0] req_y;
   logic [44:0] req_colour;
   logic [2:0]  req_ready;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [14:0] colour;
   logic        writeEn;
   logic [1:0]  owner;
   logic        locked;
   logic [7:0]  clip_cnt;

   logic [7:0]  px_x [3];
   logic [6:0]  px_y [3];
   logic [14:0] px_c [3];

   pix_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   beat_no  = 0;

   vga_write_arbiter #(
      .NUM_REQ      (3),
      .XMAX         (159),
      .YMAX         (119),
      .LOCK_TIMEOUT (64)
   ) dut (
      .CLOCK      (CLOCK),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .req_ready  (req_ready),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .writeEn    (writeEn),
      .owner      (owner),
      .locked     (locked),
      .clip_cnt   (clip_cnt)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         req_x[i*8 +: 8]       = px_x[i];
         req_y[i*7 +: 7]       = px_y[i];
         req_colour[i*15 +: 15] = px_c[i];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLOCK) begin
      pix_t e;
      if (writeEn === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got x=%0d y=%0d c=0x%0h expected no write at %0t",
                     x, y, colour, $time);
         end else begin
            e = sb.pop_front();
            chk("pixel", 32'({x, y, colour}), 32'(e));
         end
      end
   end

   task automatic set_all(input int b);
      for (int i = 0; i < 3; i++) begin
         px_x[i] = 8'(20 + 10*i + (b % 100));
         px_y[i] = 7'(3*i + (b % 100));
         px_c[i] = 15'(b*256 + i);
      end
   endtask

   // Called at posedge+1; drives one cycle and pushes the pixel of requester g (g<0: none).
   task automatic step(input logic [2:0] v, input logic [2:0] l,
                       input logic [2:0] exp_rdy, input int g);
      pix_t e;
      req_valid = v;
      req_last  = l;
      #2;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
         e = {px_x[g], px_y[g], px_c[g]};
         sb.push_back(e);
      end
      @(posedge CLOCK);
      #1;
   endtask

   task automatic nstep(input logic [2:0] v, input logic [2:0] l,
                        input logic [2:0] exp_rdy, input int g);
      beat_no++;
      set_all(beat_no);
      step(v, l, exp_rdy, g);
   endtask

   initial begin
      resetn    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      set_all(0);
      #2;
      chk("rst_writeEn", 32'(writeEn), 0);
      chk("rst_xyc", 32'({x, y, colour}), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_clip_cnt", 32'(clip_cnt), 0);
      #10 resetn = 1'b1;
      @(posedge CLOCK);
      #1;

      // single beat from req0
      px_x[0] = 8'd5; px_y[0] = 7'd7; px_c[0] = 15'h7FFF;
      step(3'b001, 3'b001, 3'b001, 0);
      chk("t1_writeEn", 32'(writeEn), 1);
      chk("t1_x", 32'(x), 5);
      chk("t1_colour", 32'(colour), 32'h7FFF);
      step(3'b000, 3'b000, 3'b000, -1);

      // all single-beat, rr_ptr starts at 1
      nstep(3'b111, 3'b111, 3'b010, 1);
      nstep(3'b111, 3'b111, 3'b100, 2);
      nstep(3'b111, 3'b111, 3'b001, 0);
      nstep(3'b111, 3'b111, 3'b010, 1);
      nstep(3'b111, 3'b111, 3'b100, 2);
      nstep(3'b111, 3'b111, 3'b001, 0);

      // req1 4-beat burst with others contending
      for (int i = 0; i < 3; i++) begin
         nstep(3'b111, 3'b101, 3'b010, 1);
         chk("t3_locked", 32'(locked), 1);
         chk("t3_owner", 32'(owner), 1);
      end
      nstep(3'b111, 3'b111, 3'b010, 1);
      chk("t3_unlocked", 32'(locked), 0);
      nstep(3'b101, 3'b101, 3'b100, 2);

      // req2 stalls its burst; timeout releases the lock
      nstep(3'b100, 3'b000, 3'b100, 2);
      chk("t4_locked", 32'(locked), 1);
      for (int i = 0; i < 63; i++) step(3'b001, 3'b001, 3'b000, -1);
      chk("t4_still_locked", 32'(locked), 1);
      step(3'b001, 3'b001, 3'b000, -1);
      chk("t4_timeout", 32'(locked), 0);
      nstep(3'b001, 3'b001, 3'b001, 0);

      // reset during req0 burst beat 2
      nstep(3'b001, 3'b000, 3'b001, 0);
      req_valid = 3'b011;
      req_last  = 3'b000;
      #2;
      chk("t5_ready_beat2", 32'(req_ready), 32'(3'b001));
      #3;
      req_valid = '0;
      resetn    = 1'b0;
      #1;
      chk("t5_writeEn", 32'(writeEn), 0);
      chk("t5_locked", 32'(locked), 0);
      chk("t5_owner", 32'(owner), 0);
      #5 resetn = 1'b1;
      @(posedge CLOCK);
      #1;
      nstep(3'b110, 3'b110, 3'b010, 1);

      // out-of-range beat from req0
      px_x[0] = 8'd200; px_y[0] = 7'd10; px_c[0] = 15'h1234;
`ifdef VGA_ARB_CLIP_EN
      step(3'b001, 3'b001, 3'b001, -1);
      chk("t6_clip_cnt1", 32'(clip_cnt), 1);
      for (int i = 0; i < 299; i++) step(3'b001, 3'b001, 3'b001, -1);
      chk("t6_clip_sat", 32'(clip_cnt), 255);
`else
      step(3'b001, 3'b001, 3'b001, 0);
      chk("t6_clip_cnt0", 32'(clip_cnt), 0);
`endif

      req_valid = '0;
      req_last  = '0;
      repeat (3) @(posedge CLOCK);
      #1;
      chk("sb_empty", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
